// File: rtl/patt_gen.sv
// Serial bit-pattern transmitter: sends a latched W-bit pattern MSB-first, reps times,
// with GAP idle cycles between repetitions, then pulses done for one cycle.
module patt_gen #(
  parameter int   W        = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [W-1:0]     pat_in,
  input  logic [CNT_W-1:0] reps,
  output logic             o,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BC_W  = $clog2(W);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             o_q, o_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, so back-to-back jobs lose no cycle.
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d   = pat_in;
          shreg_d = pat_in;
          rep_d   = reps;
          bit_d   = BIT_LAST;
          state_d = (reps != '0) ? S_SEND : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        shreg_d = {shreg_q[W-2:0], 1'b0};
        if (bit_q == '0) begin
          if (rep_q > CNT_W'(1)) begin
            rep_d = rep_q - CNT_W'(1);
            bit_d = BIT_LAST;
            if (GAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              shreg_d = pat_q;
            end
          end else begin
            if (rep_q != '0) rep_d = rep_q - CNT_W'(1);
            state_d = S_DONE;
          end
        end else begin
          bit_d = bit_q - BC_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_SEND;
          shreg_d = pat_q;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the ports come straight from flops.
    o_d     = (state_d == S_SEND) ? shreg_d[W-1] : IDLE_BIT;
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      o_q     <= IDLE_BIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o     = o_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_patt_gen.sv
// Bench for patt_gen: a GAP=1 and a GAP=0 instance share stimulus and are each checked
// cycle by cycle against an expected-output stream built from the transmit rules.
module tb_patt_gen;
  localparam int W     = 4;
  localparam int CNT_W = 4;

  // Expected-output tuples: {o, valid, busy, done}
  localparam logic [3:0] IDLE_T = 4'b0000;
  localparam logic [3:0] DONE_T = 4'b0001;
  localparam logic [3:0] GAP_T  = 4'b0010;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             start;
  logic [W-1:0]     pat_in;
  logic [CNT_W-1:0] reps;
  logic             o1, valid1, busy1, done1;
  logic             o0, valid0, busy0, done0;

  int checks   = 0;
  int failures = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];
  logic [3:0] tmp_q[$];
  logic [3:0] cur1 = IDLE_T;
  logic [3:0] cur0 = IDLE_T;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  patt_gen #(.W(W), .CNT_W(CNT_W), .GAP(1), .IDLE_BIT(1'b0)) dut_g1 (
    .clk(clk), .rst_b(rst_b), .start(start), .pat_in(pat_in), .reps(reps),
    .o(o1), .valid(valid1), .busy(busy1), .done(done1)
  );

  patt_gen #(.W(W), .CNT_W(CNT_W), .GAP(0), .IDLE_BIT(1'b0)) dut_g0 (
    .clk(clk), .rst_b(rst_b), .start(start), .pat_in(pat_in), .reps(reps),
    .o(o0), .valid(valid0), .busy(busy0), .done(done0)
  );

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Whole transmission as a list of cycles: reps patterns, gap cycles between, one done.
  task automatic build(input int gap, input logic [W-1:0] pat, input int r);
    tmp_q.delete();
    for (int rr = 0; rr < r; rr++) begin
      for (int b = W - 1; b >= 0; b--) tmp_q.push_back({pat[b], 3'b110});
      if (rr < r - 1)
        for (int g = 0; g < gap; g++) tmp_q.push_back(GAP_T);
    end
    tmp_q.push_back(DONE_T);
  endtask

  // One clock: advance the model on the sampled inputs, then compare both DUTs.
  task automatic step();
    @(posedge clk);
    if (!rst_b) begin
      q1.delete();
      q0.delete();
      cur1 = IDLE_T;
      cur0 = IDLE_T;
    end else begin
      if (start && !cur1[1]) begin
        build(1, pat_in, int'(reps));
        q1 = tmp_q;
      end
      if (start && !cur0[1]) begin
        build(0, pat_in, int'(reps));
        q0 = tmp_q;
      end
      if (q1.size() > 0) cur1 = q1.pop_front(); else cur1 = IDLE_T;
      if (q0.size() > 0) cur0 = q0.pop_front(); else cur0 = IDLE_T;
    end
    #1;
    check_eq("out_gap1", {o1, valid1, busy1, done1}, cur1);
    check_eq("out_gap0", {o0, valid0, busy0, done0}, cur0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] p, input logic [CNT_W-1:0] r);
    pat_in = p;
    reps   = r;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  int busy_cnt, valid_cnt, done_cnt;
  bit found;

  initial begin
    rst_b  = 1'b0;
    start  = 1'b0;
    pat_in = '0;
    reps   = '0;
    step();
    step();
    check_eq("reset_outputs", {o1, valid1, busy1, done1, o0, valid0, busy0, done0}, 8'h00);
    rst_b = 1'b1;
    step();

    // Single repetition of 1011.
    send(4'b1011, 4'd1);
    check_eq("first_bit", {o1, valid1, busy1}, 3'b111);
    for (int i = 0; i < 8; i++) step();

    // Three repetitions: busy length and single done on both builds.
    pat_in = 4'b1011; reps = 4'd3; start = 1'b1;
    busy_cnt = 0; valid_cnt = 0; done_cnt = 0;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      busy_cnt  += int'(busy1);
      valid_cnt += int'(valid0);
      done_cnt  += int'(done1) + int'(done0);
      step();
    end
    check_eq("busy_len_r3_gap1", busy_cnt, 14);
    check_eq("valid_len_r3_gap0", valid_cnt, 12);
    check_eq("done_pulses_r3", done_cnt, 2);

    // Back-to-back on the GAP=0 build.
    pat_in = 4'b1011; reps = 4'd2; start = 1'b1;
    valid_cnt = 0;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      valid_cnt += int'(valid0);
      step();
    end
    check_eq("valid_len_r2_gap0", valid_cnt, 8);

    // Zero repetitions: immediate done, nothing sent.
    send(4'b1111, 4'd0);
    check_eq("reps0_done", {o1, valid1, busy1, done1}, 4'b0001);
    for (int i = 0; i < 3; i++) step();

    // Start with a new pattern mid-flight is ignored; start during done restarts.
    send(4'b1011, 4'd2);
    step();
    step();
    send(4'b0110, 4'd5);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (cur1 == DONE_T) found = 1'b1;
    end
    check_eq("wait_done", found, 1'b1);
    send(4'b1100, 4'd1);
    check_eq("restart_from_done", {o1, valid1, busy1, done1}, 4'b1110);
    for (int i = 0; i < 12; i++) step();

    // Reset in the middle of the second repetition aborts without done.
    send(4'b1011, 4'd3);
    for (int i = 0; i < 6; i++) step();
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check_eq("abort_outputs", {valid1, busy1, done1, valid0, busy0, done0}, 6'b0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      done_cnt += int'(done1) + int'(done0);
    end
    check_eq("no_done_after_abort", done_cnt, 0);
    send(4'b1001, 4'd1);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      pat_in = W'($urandom);
      reps   = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 4));
      rst_b  = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_b = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
